imem_boot_loader: RTL and testbench

//  Synthesisable successor to hand-poked instruction-memory preload for the MIPS_R2000 pipeline.

---
 rtl/imem_boot_loader.sv | 161 ++++++++++++++++
 tb/tb_imem_boot_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Boot loader for the MIPS_R2000 instruction memory. Instruction words arrive
//   on a valid/ready stream and are written into the byte-addressed,
//   little-endian imem one byte per cycle. The CPU is held in reset while
//   loading. It is then released for a bounded run that a watchdog measures.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   in_valid/ready  word stream handshake; in_data word, in_last final word
//   mem_we/addr/wdata  imem byte write port (addr/wdata are 0 when we=0)
//   cpu_rst         CPU reset, high while loading
//   running         CPU released, watchdog counting
//   done            run window expired (sticky until rst)
//   overflow_err    a word was dropped because it would not fit (sticky)
//   word_count      words actually written since reset
//   state_dbg       current FSM state (LOAD=0, WRITE=1, RUN=2, DONE=3)
//
// Handshake: a word transfers on a rising edge where in_valid and in_ready
// are both high. in_data and in_last are sampled only on that edge. While
// in_ready is low, in_valid is ignored, and the source must hold its word
// until a transfer occurs.
module imem_boot_loader #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 10,
  parameter int START_ADDR = 0,
  parameter int RUN_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_rst,
  output logic              running,
  output logic              done,
  output logic              overflow_err,
  output logic [ADDR_W-1:0] word_count,
  output logic [1:0]        state_dbg
);

  localparam int BYTES = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BYTES - 1);
  localparam logic [ADDR_W:0]   START_PTR = (ADDR_W + 1)'(START_ADDR);
  localparam logic [ADDR_W:0]   BYTES_PTR = (ADDR_W + 1)'(BYTES);
  localparam logic [ADDR_W+1:0] DEPTH_EXT = (ADDR_W + 2)'(DEPTH);
  localparam logic [ADDR_W+1:0] BYTES_EXT = (ADDR_W + 2)'(BYTES);
  localparam logic [31:0]       RUN_LAST  = 32'(RUN_CYCLES - 1);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_WRITE = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W:0]   ptr;       // one extra bit: the DEPTH boundary is seen without wrap
  logic [IDX_W-1:0]  byte_idx;  // index of the byte currently presented on mem_*
  logic [31:0]       cyc;
  logic [DATA_W-1:0] shift_q;   // remaining bytes of the word, next byte in [7:0]
  logic              last_q;
  logic              fits;

  // The test is done one bit wider than ptr, so ptr+BYTES cannot wrap.
  assign fits      = ({1'b0, ptr} + BYTES_EXT) <= DEPTH_EXT;
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_LOAD;
      ptr          <= START_PTR;
      byte_idx     <= '0;
      cyc          <= '0;
      shift_q      <= '0;
      last_q       <= 1'b0;
      in_ready     <= 1'b1;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_rst      <= 1'b1;
      running      <= 1'b0;
      done         <= 1'b0;
      overflow_err <= 1'b0;
      word_count   <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          // in_ready is always high in LOAD, so in_valid alone marks a transfer.
          if (in_valid) begin
            if (fits) begin
              // Byte 0 is presented immediately and is written on the next edge.
              state     <= S_WRITE;
              last_q    <= in_last;
              in_ready  <= 1'b0;
              mem_we    <= 1'b1;
              mem_addr  <= ptr[ADDR_W-1:0];
              mem_wdata <= in_data[7:0];
              shift_q   <= in_data >> 8;
              byte_idx  <= '0;
            end else begin
              overflow_err <= 1'b1;
              if (in_last) begin
                state    <= S_RUN;
                in_ready <= 1'b0;
                cpu_rst  <= 1'b0;
                running  <= 1'b1;
              end
            end
          end
        end

        S_WRITE: begin
          if (byte_idx == LAST_IDX) begin
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            ptr        <= ptr + BYTES_PTR;
            word_count <= word_count + 1'b1;
            if (last_q) begin
              state   <= S_RUN;
              cpu_rst <= 1'b0;
              running <= 1'b1;
            end else begin
              state    <= S_LOAD;
              in_ready <= 1'b1;
            end
          end else begin
            byte_idx  <= byte_idx + 1'b1;
            mem_addr  <= mem_addr + 1'b1;
            mem_wdata <= shift_q[7:0];
            shift_q   <= shift_q >> 8;
          end
        end

        S_RUN: begin
          if ((RUN_CYCLES != 0) && (cyc == RUN_LAST)) begin
            state   <= S_DONE;
            running <= 1'b0;
            done    <= 1'b1;
          end else if (cyc != 32'hFFFF_FFFF) begin
            cyc <= cyc + 1'b1;
          end
        end

        // Terminal: the CPU is left out of reset so its state can be inspected.
        S_DONE: begin
        end

        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 5;
  localparam int RUN_CYCLES = 10;
  localparam int BYTES      = DATA_W / 8;
  localparam int DEPTH      = 2 ** ADDR_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_last = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              cpu_rst;
  logic              running;
  logic              done;
  logic              overflow_err;
  logic [ADDR_W-1:0] word_count;
  logic [1:0]        state_dbg;

  imem_boot_loader #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .START_ADDR(0), .RUN_CYCLES(RUN_CYCLES)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst(cpu_rst), .running(running), .done(done),
    .overflow_err(overflow_err), .word_count(word_count), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [ADDR_W+7:0] exp_q[$];   // {addr, byte} expected imem writes in order
  logic [7:0] ref_mem [DEPTH];
  bit         touched [DEPTH];
  logic [7:0] imem    [DEPTH];   // imem as seen through the DUT write port
  logic [31:0] words[$];

  // reference model state
  int m_ptr;
  int m_count;
  bit m_ovf;
  bit m_written;
  bit m_prev_written;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) if (mem_we) imem[mem_addr] <= mem_wdata;

  // monitor: every presented byte write must match the next expected one
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_write actual addr=%0d data=%02h required no write at %0t",
                   mem_addr, mem_wdata, $time);
        end else begin
          check("mem_write", {mem_addr, mem_wdata}, exp_q.pop_front());
        end
      end else begin
        check("mem_idle_zero", {mem_addr, mem_wdata}, 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  task automatic model_reset();
    m_ptr = 0;
    m_count = 0;
    m_ovf = 1'b0;
    m_written = 1'b0;
    m_prev_written = 1'b0;
  endtask

  // nbytes < BYTES models a word whose write is cut short by reset
  task automatic model_accept(input logic [31:0] d, input int nbytes);
    if (m_ptr + BYTES <= DEPTH) begin
      for (int k = 0; k < nbytes; k++) begin
        exp_q.push_back({ADDR_W'(m_ptr + k), d[8*k +: 8]});
        ref_mem[m_ptr + k] = d[8*k +: 8];
        touched[m_ptr + k] = 1'b1;
      end
      if (nbytes == BYTES) begin
        m_ptr += BYTES;
        m_count++;
      end
      m_written = 1'b1;
    end else begin
      m_ovf = 1'b1;
      m_written = 1'b0;
    end
    m_prev_written = m_written;
  endtask

  // ---------------- driver tasks (enter and leave at a negedge) ----------------
  task automatic apply_reset();
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("reset_outputs",
          {in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, running, done, overflow_err, word_count},
          {1'b1, 1'b0, 5'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0});
  endtask

  task automatic send_word(input logic [31:0] d, input bit last, input int gap, input int nbytes);
    int waits;
    int exp_waits;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    // a written word keeps in_ready low for BYTES cycles after its transfer
    exp_waits = (m_prev_written && (BYTES - gap > 0)) ? BYTES - gap : 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    waits = 0;
    while (!in_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    check("ready_wait", waits, exp_waits);
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_accept(d, nbytes);
    @(negedge clk);
  endtask

  task automatic finish_run();
    int c;
    int r;
    int bad;
    in_valid = 1'b0;
    c = 0;
    while (cpu_rst && c < 50) begin
      c++;
      @(negedge clk);
    end
    check("cpu_rst_release", c, m_written ? BYTES : 0);
    r = 0;
    while (running && r < 100) begin
      r++;
      @(negedge clk);
    end
    check("running_cycles", r, RUN_CYCLES);
    check("done_state", {done, running, cpu_rst, in_ready}, 4'b1000);
    repeat (3) @(negedge clk);
    check("done_sticky", {done, running, cpu_rst}, 3'b100);
    check("word_count", word_count, m_count);
    check("overflow_err", overflow_err, m_ovf);
    check("queue_drained", exp_q.size(), 0);
    bad = 0;
    for (int i = 0; i < DEPTH; i++)
      if (touched[i] && imem[i] !== ref_mem[i]) bad++;
    check("imem_contents", bad, 0);
  endtask

  task automatic run_list(input bit rand_gaps);
    int gap;
    for (int i = 0; i < words.size(); i++) begin
      gap = 0;
      if (rand_gaps && $urandom_range(0, 2) == 0) gap = $urandom_range(1, 6);
      send_word(words[i], i == words.size() - 1, gap, BYTES);
    end
    finish_run();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int bad;
    int n;
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = 8'h00;
      touched[i] = 1'b0;
    end
    model_reset();

    // three-word program, back to back
    apply_reset();
    words = {32'h2042_0001, 32'h2063_0002, 32'h2084_0003};
    run_list(1'b0);

    // more words than fit: the ninth is dropped, the run still starts
    apply_reset();
    words.delete();
    for (int i = 0; i < 9; i++) words.push_back($urandom);
    run_list(1'b0);

    // reset in the middle of word 2 after two of its bytes are written
    apply_reset();
    send_word(32'hA1B2_C3D4, 1'b0, 0, BYTES);
    send_word(32'h5566_7788, 1'b0, 0, 2);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("count_before_abort", word_count, 1);
    rst = 1'b1;
    #1;
    check("async_reset", {cpu_rst, in_ready, mem_we, word_count}, {1'b1, 1'b1, 1'b0, 5'd0});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("abort_queue", exp_q.size(), 0);
    bad = 0;
    for (int i = 0; i < DEPTH; i++)
      if (touched[i] && imem[i] !== ref_mem[i]) bad++;
    check("abort_partial_bytes", bad, 0);
    words = {32'h0BAD_F00D, 32'h1234_5678};
    run_list(1'b0);

    // randomized loads with random source gaps
    for (int s = 0; s < 12; s++) begin
      apply_reset();
      words.delete();
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) words.push_back($urandom);
      run_list(1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
